// File: rtl/mem_bus_arbiter.sv
// Registered request/grant arbiter sharing one memory port between instruction fetch and data access.
// Define ARB_FAIRNESS_EN to bound consecutive data grants while fetch is waiting.
module mem_bus_arbiter #(
    parameter int unsigned AW             = 64,
    parameter int unsigned DW             = 64,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned MAX_MEM_STREAK = 4
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          mem_req,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] mem_rdata,
    output logic          mem_ready,
    output logic          PSEL,
    output logic [AW-1:0] PADDR,
    output logic          PWRITE,
    output logic [DW-1:0] PWDATA,
    input  logic [DW-1:0] PRDATA,
    input  logic          PREADY,
    output logic          bus_err,
    output logic          stall
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, XFER_IF, XFER_MEM} state_t;

    state_t          r_state, w_next_state;
    logic [CW-1:0]   r_wait_cnt;
    logic [AW-1:0]   r_paddr;
    logic            r_pwrite;
    logic [DW-1:0]   r_pwdata;
    logic [DW-1:0]   r_if_rdata, r_mem_rdata;
    logic            r_if_ready, r_mem_ready, r_bus_err;
    logic            w_xfer, w_done, w_abort;
    logic            w_grant_if, w_grant_mem, w_fetch_first;

    assign w_xfer  = (r_state != IDLE);
    assign w_done  = w_xfer & PREADY;
    // PREADY on the final wait cycle wins over the abort.
    assign w_abort = w_xfer & ~PREADY & (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1));

`ifdef ARB_FAIRNESS_EN
    localparam int unsigned SW = $clog2(MAX_MEM_STREAK + 1);
    logic [SW-1:0] r_streak;

    assign w_fetch_first = if_req & (r_streak == SW'(MAX_MEM_STREAK));

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_streak <= '0;
        end else if (r_state == IDLE) begin
            if (!if_req || w_grant_if) r_streak <= '0;
            else if (w_grant_mem)      r_streak <= r_streak + 1'b1;
        end
    end
`else
    assign w_fetch_first = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        w_grant_if   = 1'b0;
        w_grant_mem  = 1'b0;
        case (r_state)
            IDLE: begin
                if (mem_req && !w_fetch_first) begin
                    w_grant_mem  = 1'b1;
                    w_next_state = XFER_MEM;
                end else if (if_req) begin
                    w_grant_if   = 1'b1;
                    w_next_state = XFER_IF;
                end
            end
            XFER_IF, XFER_MEM: begin
                if (w_done || w_abort) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_wait_cnt  <= '0;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
            r_if_ready  <= 1'b0;
            r_mem_ready <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_if_ready  <= 1'b0;
            r_mem_ready <= 1'b0;
            r_bus_err   <= 1'b0;
            if (w_grant_mem) begin
                r_paddr    <= mem_addr;
                r_pwrite   <= mem_we;
                r_pwdata   <= mem_wdata;
                r_wait_cnt <= '0;
            end else if (w_grant_if) begin
                r_paddr    <= if_addr;
                r_pwrite   <= 1'b0;
                r_pwdata   <= '0;
                r_wait_cnt <= '0;
            end else if (w_xfer && !PREADY && !w_abort) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end

            if (w_done) begin
                if (r_state == XFER_IF) begin
                    r_if_rdata <= PRDATA;
                    r_if_ready <= 1'b1;
                end else begin
                    if (!r_pwrite) r_mem_rdata <= PRDATA;
                    r_mem_ready <= 1'b1;
                end
            end else if (w_abort) begin
                r_bus_err <= 1'b1;
                if (r_state == XFER_IF) begin
                    r_if_rdata <= '0;
                    r_if_ready <= 1'b1;
                end else begin
                    r_mem_rdata <= '0;
                    r_mem_ready <= 1'b1;
                end
            end
        end
    end

    assign PSEL      = w_xfer;
    assign PADDR     = r_paddr;
    assign PWRITE    = r_pwrite;
    assign PWDATA    = r_pwdata;
    assign if_rdata  = r_if_rdata;
    assign if_ready  = r_if_ready;
    assign mem_rdata = r_mem_rdata;
    assign mem_ready = r_mem_ready;
    assign bus_err   = r_bus_err;
    // Gated by reset so every output reads 0 while reset is held.
    assign stall     = RESET & ((if_req & ~r_if_ready) | (mem_req & ~r_mem_ready));

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Sequencing arbiter that shares the single internal memory port between the instruction-fetch requester and the memory-access requester.
- Replaces the combinational address mux with a registered request/grant state machine.
- Supports slave wait states through PREADY and a bounded timeout.
- Produces per-port ready pulses and the pipeline stall used by inst_fetch, inst_decode and mem_access.

Parameters:
- AW, 64, address width.
- DW, 64, data width.
- TIMEOUT_CYCLES, 16, maximum bus cycles without PREADY before the transfer is aborted.
- MAX_MEM_STREAK, 4, consecutive data-port grants allowed while fetch waits; only used with ARB_FAIRNESS_EN.

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  AW  fetch address
- if_rdata  out  DW  fetch read data, valid on if_ready
- if_ready  out  1  one-cycle fetch completion pulse
- mem_req  in  1  data request; held until mem_ready
- mem_we  in  1  1 = write
- mem_addr  in  AW  data address
- mem_wdata  in  DW  write data
- mem_rdata  out  DW  load data, valid on mem_ready
- mem_ready  out  1  one-cycle data completion pulse
- PSEL  out  1  slave select, high for the whole transfer
- PADDR  out  AW  slave address
- PWRITE  out  1  slave write enable
- PWDATA  out  DW  slave write data
- PRDATA  in  DW  slave read data
- PREADY  in  1  slave transfer complete
- bus_err  out  1  one-cycle pulse on timeout abort
- stall  out  1  pipeline stall

Behaviour:
- Reset: CLK with RESET asynchronous, active-low. While RESET=0, all outputs are 0, state is IDLE, and all counters are 0.
- States: IDLE, XFER_IF, XFER_MEM.
- IDLE: on a clock edge with mem_req=1, go to XFER_MEM. Otherwise, with if_req=1, go to XFER_IF. Data port has fixed priority. Default arbitration is strict priority, so fetch can starve under continuous data traffic.
- On grant: latch the requester's addr, we and wdata into bus registers. For fetch, PWRITE=0.
- PSEL/PADDR/PWRITE/PWDATA are driven from registers only, never combinationally from the request inputs.
- XFER_*: PSEL=1 and outputs stable until completion.
- Completion on a clock edge with PREADY=1:
  - capture PRDATA into the granted port's rdata register (writes leave mem_rdata unchanged);
  - pulse that port's ready for exactly 1 cycle;
  - PSEL drops to 0 and state returns to IDLE.
- Latency: request sampled at edge N → PSEL high in cycle N..N+1. If PREADY is already high then, ready is high in cycle N+1..N+2. Minimum is 2 edges from request to ready.
- Back-to-back: at least one IDLE cycle separates transfers, with PSEL low for 1 cycle. A requester holding req high during its ready cycle is treated as a new request at the next IDLE edge.
- Timeout: the wait counter increments each XFER cycle with PREADY=0. When it reaches TIMEOUT_CYCLES-1 without PREADY:
  - abort the transfer and pulse bus_err;
  - pulse the granted port's ready with rdata forced to 0;
  - return to IDLE.
  The counter clears on every grant.
- Simultaneous events: if PREADY and the timeout arrive on the same edge, PREADY wins and no bus_err is raised.
- Stall is combinational: stall = (if_req & ~if_ready) | (mem_req & ~mem_ready).
- Requests deasserted mid-transfer do not cancel it. The transfer completes and the ready pulse is still issued.
- Reset asserted mid-transfer drops PSEL immediately and no ready pulse is produced.

Optional Feature:
- Macro: ARB_FAIRNESS_EN.
- When defined: a streak counter counts consecutive XFER_MEM grants made while if_req=1.
  - When the count equals MAX_MEM_STREAK, the next IDLE decision grants fetch even if mem_req=1.
  - The counter clears on any XFER_IF grant, or on any IDLE cycle with if_req=0.
- When undefined: strict data-port priority applies, and no counter logic is synthesized.

Test Plan:
- Fetch alone: if_req=1, if_addr=0x100, PREADY tied 1, PRDATA=0x13. Expect PSEL high for 1 cycle with PADDR=0x100, then if_ready pulse with if_rdata=0x13, 2 edges after request.
- Contention: if_req and mem_req asserted on the same edge, mem_we=1, mem_addr=0x2000, mem_wdata=0xDEAD.
  - XFER_MEM first, with PWRITE=1 and PWDATA=0xDEAD, then mem_ready.
  - Then one IDLE cycle, then XFER_IF and if_ready.
  - stall stays 1 until if_ready.
- Wait states: PREADY delayed 3 cycles on a load with PRDATA=0xCAFE. Expect PSEL held for 4 cycles with constant PADDR, and mem_ready with mem_rdata=0xCAFE.
- Timeout: PREADY held 0 with TIMEOUT_CYCLES=16. Expect bus_err and if_ready pulsing together after the 16th XFER cycle, with if_rdata=0.
- Reset mid-transfer: RESET=0 during XFER_MEM. Expect PSEL=0 immediately and no mem_ready; after release, a fresh request completes normally.
- Fairness (ARB_FAIRNESS_EN, MAX_MEM_STREAK=4): mem_req and if_req held continuously. Expect 4 data grants, then 1 fetch grant, repeating.
